// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with destination scoreboard.
// Two requesters (single-cycle ALU writeback and multi-cycle load/mul unit)
// share one register-file write port under round-robin arbitration. The
// accepted write is presented one cycle later. A 32-entry reservation bitmap
// tracks destinations claimed by in-flight producers and drives the decode stall.
module regfile_write_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    // requester 0: single-cycle ALU writeback
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [4:0]        req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    // requester 1: multi-cycle load/mul unit
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [4:0]        req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    // destination reservation from issue
    input  logic              claim_en,
    input  logic [4:0]        claim_addr,
    input  logic              flush,
    // decode-stage hazard check
    input  logic [4:0]        src_addr1,
    input  logic [4:0]        src_addr2,
    output logic              stall,
    output logic [31:0]       pending,
    // register-file write port
    output logic              rf_write_en,
    output logic [4:0]        rf_dst_addr,
    output logic [DATA_W-1:0] rf_dst_data
);

    // Index of the requester granted most recently; 1 after reset so that
    // requester 0 wins the first tie.
    logic              last_grant_reg;
    logic              last_grant_next;

    logic              grant0;
    logic              grant1;
    logic              accept0;
    logic              accept1;

    logic              rf_write_en_reg;
    logic              rf_write_en_next;
    logic [4:0]        rf_dst_addr_reg;
    logic [4:0]        rf_dst_addr_next;
    logic [DATA_W-1:0] rf_dst_data_reg;
    logic [DATA_W-1:0] rf_dst_data_next;

    logic [31:0]       pending_reg;
    logic [31:0]       pending_next;

    // Round-robin grant: a lone requester always wins; on a tie the one not
    // granted last wins. Readies are held low while reset is asserted.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant_reg);
        grant1     = req1_valid & (~req0_valid | ~last_grant_reg);
        req0_ready = reset & grant0;
        req1_ready = reset & grant1;
        accept0    = req0_valid & req0_ready;
        accept1    = req1_valid & req1_ready;
    end

    // Next write-port contents and arbitration history.
    always_comb begin
        last_grant_next  = last_grant_reg;
        rf_dst_addr_next = rf_dst_addr_reg;
        rf_dst_data_next = rf_dst_data_reg;
        if (accept0) begin
            last_grant_next  = 1'b0;
            rf_dst_addr_next = req0_addr;
            rf_dst_data_next = req0_data;
        end else if (accept1) begin
            last_grant_next  = 1'b1;
            rf_dst_addr_next = req1_addr;
            rf_dst_data_next = req1_data;
        end
        // Writes to r0 are consumed but never reach the register file.
        rf_write_en_next = (accept0 | accept1) & (rf_dst_addr_next != 5'd0);
    end

    // Register r0 can never be reserved.
    assign pending_next[0] = 1'b0;

    // Per-register reservation update: flush clears everything, a claim beats
    // a same-edge clear from an accepted write to the same index.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            always_comb begin
                set_bit = claim_en & (claim_addr == 5'(gi));
                clr_bit = (accept0 & (req0_addr == 5'(gi)))
                        | (accept1 & (req1_addr == 5'(gi)));
                if (flush) begin
                    pending_next[gi] = 1'b0;
                end else begin
                    pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
                end
            end
        end
    endgenerate

    // State registers; reset drops any write not yet presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_reg  <= 1'b1;
            rf_write_en_reg <= 1'b0;
            rf_dst_addr_reg <= '0;
            rf_dst_data_reg <= '0;
            pending_reg     <= '0;
        end else begin
            last_grant_reg  <= last_grant_next;
            rf_write_en_reg <= rf_write_en_next;
            rf_dst_addr_reg <= rf_dst_addr_next;
            rf_dst_data_reg <= rf_dst_data_next;
            pending_reg     <= pending_next;
        end
    end

    // Hazard check against the registered reservations.
    always_comb begin
        stall = pending_reg[src_addr1] | pending_reg[src_addr2];
    end

    assign pending     = pending_reg;
    assign rf_write_en = rf_write_en_reg;
    assign rf_dst_addr = rf_dst_addr_reg;
    assign rf_dst_data = rf_dst_data_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a reference model predicts
// readies and reservations each cycle and queues the expected write-port
// contents, which are popped and compared one cycle later.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [4:0]        req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              claim_en;
    logic [4:0]        claim_addr;
    logic              flush;
    logic [4:0]        src_addr1, src_addr2;
    logic              stall;
    logic [31:0]       pending;
    logic              rf_write_en;
    logic [4:0]        rf_dst_addr;
    logic [DATA_W-1:0] rf_dst_data;

    regfile_write_arbiter #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .claim_en    (claim_en),
        .claim_addr  (claim_addr),
        .flush       (flush),
        .src_addr1   (src_addr1),
        .src_addr2   (src_addr2),
        .stall       (stall),
        .pending     (pending),
        .rf_write_en (rf_write_en),
        .rf_dst_addr (rf_dst_addr),
        .rf_dst_data (rf_dst_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              en;
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    wr_exp_t     sb_q[$];
    logic [31:0] m_pend;
    logic        m_last;
    int          n_checks;
    int          n_fail;
    bit          a0, a1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven (posedge+1). At the falling
    // edge compare outputs with the model, then advance the model to the edge.
    task automatic run_cycle(output bit acc0, output bit acc1);
        wr_exp_t     e;
        bit          r0, r1;
        logic [31:0] clr, set;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq("wr_en", rf_write_en, e.en);
            if (e.en) begin
                check_eq("wr_addr", rf_dst_addr, e.addr);
                check_eq("wr_data", rf_dst_data, e.data);
            end
        end
        check_eq("pending", pending, m_pend);
        check_eq("stall", stall, m_pend[src_addr1] | m_pend[src_addr2]);
        r0 = req0_valid && (!req1_valid || m_last);
        r1 = req1_valid && (!req0_valid || !m_last);
        check_eq("req0_ready", req0_ready, r0);
        check_eq("req1_ready", req1_ready, r1);
        check_eq("one_ready", req0_ready & req1_ready, 1'b0);
        $display("cycle t=%0t v=%b%b rdy=%b%b wr_en=%b addr=%0d data=%0h pend=%0h stall=%b",
                 $time, req0_valid, req1_valid, req0_ready, req1_ready,
                 rf_write_en, rf_dst_addr, rf_dst_data, pending, stall);
        acc0 = r0;
        acc1 = r1;
        clr  = '0;
        set  = '0;
        if (r0) begin
            sb_q.push_back('{en: (req0_addr != 0), addr: req0_addr, data: req0_data});
            clr[req0_addr] = 1'b1;
            m_last = 1'b0;
        end else if (r1) begin
            sb_q.push_back('{en: (req1_addr != 0), addr: req1_addr, data: req1_data});
            clr[req1_addr] = 1'b1;
            m_last = 1'b1;
        end else begin
            sb_q.push_back('{en: 1'b0, addr: 5'd0, data: '0});
        end
        if (claim_en) set[claim_addr] = 1'b1;
        if (flush) m_pend = '0;
        else       m_pend = (m_pend & ~clr) | set;
        m_pend[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_addr  = 0; req1_addr  = 0;
        req0_data  = 0; req1_data  = 0;
        claim_en   = 0; claim_addr = 0; flush = 0;
        src_addr1  = 0; src_addr2  = 0;
        m_pend     = '0;
        m_last     = 1'b1;

        // Reset state
        #1;
        check_eq("rst_wr_en", rf_write_en, 1'b0);
        check_eq("rst_addr", rf_dst_addr, 5'd0);
        check_eq("rst_data", rf_dst_data, 32'd0);
        check_eq("rst_pending", pending, 32'd0);
        #11 reset = 1'b1;
        sb_q.push_back('{en: 1'b0, addr: 5'd0, data: '0});
        @(posedge clk); #1;

        // Tie from reset release: req0 first, then req1
        req0_valid = 1; req0_addr = 5'd3; req0_data = 32'hAA;
        req1_valid = 1; req1_addr = 5'd4; req1_data = 32'hBB;
        run_cycle(a0, a1);
        if (a0) req0_valid = 0;
        if (a1) req1_valid = 0;
        run_cycle(a0, a1);
        if (a0) req0_valid = 0;
        if (a1) req1_valid = 0;
        run_cycle(a0, a1);

        // Continuous contention: grants alternate, new data after each accept
        req0_valid = 1; req1_valid = 1;
        req0_addr = 5'd10; req0_data = $urandom;
        req1_addr = 5'd11; req1_data = $urandom;
        for (int i = 0; i < 6; i++) begin
            run_cycle(a0, a1);
            check_eq("rr_seq", {a1, a0}, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (a0) begin req0_addr = 5'($urandom_range(1, 31)); req0_data = $urandom; end
            if (a1) begin req1_addr = 5'($urandom_range(1, 31)); req1_data = $urandom; end
        end
        req0_valid = 0; req1_valid = 0;
        run_cycle(a0, a1);

        // Write to r0 is consumed without a register-file write
        req1_valid = 1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
        run_cycle(a0, a1);
        req1_valid = 0;
        run_cycle(a0, a1);

        // Reservation of r5, stall, clear on writeback, claim beats clear
        claim_en = 1; claim_addr = 5'd5;
        run_cycle(a0, a1);
        claim_en = 0; src_addr1 = 5'd5; src_addr2 = 5'd0;
        run_cycle(a0, a1);
        check_eq("stall_r5", stall, 1'b1);
        req1_valid = 1; req1_addr = 5'd5; req1_data = 32'h55;
        run_cycle(a0, a1);
        req1_valid = 0;
        run_cycle(a0, a1);
        check_eq("pend5_clr", pending[5], 1'b0);
        check_eq("stall_clr", stall, 1'b0);
        claim_en = 1; claim_addr = 5'd5;
        req1_valid = 1; req1_addr = 5'd5; req1_data = 32'h56;
        run_cycle(a0, a1);
        claim_en = 0; req1_valid = 0;
        run_cycle(a0, a1);
        check_eq("claim_wins", pending[5], 1'b1);

        // Several claims then flush with a simultaneous claim
        src_addr1 = 5'd2; src_addr2 = 5'd9;
        claim_en = 1;
        claim_addr = 5'd1; run_cycle(a0, a1);
        claim_addr = 5'd2; run_cycle(a0, a1);
        claim_addr = 5'd7; run_cycle(a0, a1);
        claim_addr = 5'd0; run_cycle(a0, a1);
        flush = 1; claim_addr = 5'd9;
        run_cycle(a0, a1);
        flush = 0; claim_en = 0;
        run_cycle(a0, a1);
        check_eq("flush_all", pending, 32'd0);

        // Asynchronous reset while a write is being presented
        claim_en = 1; claim_addr = 5'd3;
        run_cycle(a0, a1);
        claim_en = 0;
        req0_valid = 1; req0_addr = 5'd6; req0_data = 32'h66;
        req1_valid = 1; req1_addr = 5'd8; req1_data = 32'h88;
        run_cycle(a0, a1);
        check_eq("pre_rst_wr_en", rf_write_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_wr_en", rf_write_en, 1'b0);
        check_eq("arst_addr", rf_dst_addr, 5'd0);
        check_eq("arst_data", rf_dst_data, 32'd0);
        check_eq("arst_pending", pending, 32'd0);
        check_eq("arst_rdy0", req0_ready, 1'b0);
        check_eq("arst_rdy1", req1_ready, 1'b0);
        sb_q.delete();
        m_pend = '0;
        m_last = 1'b1;
        sb_q.push_back('{en: 1'b0, addr: 5'd0, data: '0});
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1; req0_addr = 5'd12; req0_data = 32'h1212;
        req1_valid = 1; req1_addr = 5'd13; req1_data = 32'h1313;
        run_cycle(a0, a1);
        if (a0) req0_valid = 0;
        if (a1) req1_valid = 0;
        run_cycle(a0, a1);
        if (a0) req0_valid = 0;
        if (a1) req1_valid = 0;
        run_cycle(a0, a1);
        run_cycle(a0, a1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
